// File: rtl/polar64_crc16_encoder_if.sv
// Handshake bundle for the 64-bit polar/CRC16 encoder: payload in, codeword out.
// err_mask is present only when POLAR_ENC_ERRINJ_EN is defined.
interface polar64_crc16_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] cw_out;
    logic [15:0] frame_cnt;
`ifdef POLAR_ENC_ERRINJ_EN
    logic [63:0] err_mask;
`endif

    modport slave (
`ifdef POLAR_ENC_ERRINJ_EN
        input  err_mask,
`endif
        input  in_valid,
        input  data_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output cw_out,
        output frame_cnt
    );

    modport master (
`ifdef POLAR_ENC_ERRINJ_EN
        output err_mask,
`endif
        output in_valid,
        output data_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  cw_out,
        input  frame_cnt
    );
endinterface

// File: rtl/polar64_crc16_encoder.sv
// Polar(64,40) encoder: 24-bit payload + bit-serial CRC-16/CCITT, one transform stage per cycle.
// Optional error injection onto the codeword under POLAR_ENC_ERRINJ_EN.
module polar64_crc16_encoder (
    input  logic                          clk,
    input  logic                          rst_n,
    polar64_crc16_encoder_if.slave        bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CRC   = 3'd1,
        BUILD = 3'd2,
        XFORM = 3'd3,
        OUT   = 3'd4
    } state_t;

    // CRC-16/CCITT-FALSE: init 0xFFFF, no final XOR.
    localparam logic [15:0] CRC_POLY   = 16'h1021;
    localparam logic [15:0] CRC_INIT   = 16'hFFFF;
    localparam logic [15:0] CRC_XOROUT = 16'h0000;

    // Set bits mark the 40 information positions; all others are frozen to 0.
    localparam logic [63:0] INFO_MASK  = 64'hFFFE_FEE8_FEE8_E000;

    // Number of information positions strictly below pos, i.e. its rank in the info word.
    function automatic int info_rank(input int pos);
        int r;
        r = 0;
        for (int i = 0; i < pos; i++) begin
            if (INFO_MASK[i]) r++;
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [23:0] data_q, data_d;
    logic [15:0] crc_q, crc_d;
    logic [4:0]  bit_idx_q, bit_idx_d;
    logic [2:0]  stage_q, stage_d;
    logic [63:0] u_q, u_d;
    logic [63:0] cw_q, cw_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [63:0] inj_mask;

`ifdef POLAR_ENC_ERRINJ_EN
    logic [63:0] mask_q, mask_d;
    assign inj_mask = mask_q;
`else
    assign inj_mask = 64'h0;
`endif

    logic [15:0]      crc_step;
    logic [39:0]      info_word;
    logic [63:0]      u_build;
    logic [5:0][63:0] stage_out;
    logic [63:0]      xform_v;

    assign crc_step  = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ data_q[bit_idx_q]) ? CRC_POLY : 16'h0000);
    assign info_word = {data_q, crc_q ^ CRC_XOROUT};

    // Info bits fill the information positions in ascending order, payload MSB first.
    genvar gi, gs;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_build
            if (INFO_MASK[gi]) begin : g_info
                localparam int RANK = info_rank(gi);
                assign u_build[gi] = info_word[39 - RANK];
            end else begin : g_frozen
                assign u_build[gi] = 1'b0;
            end
        end

        // stage_out[s] is u_q after applying butterfly stage s alone.
        for (gs = 0; gs < 6; gs++) begin : g_stage
            for (gi = 0; gi < 64; gi++) begin : g_bit
                if (((gi >> gs) & 1) == 0) begin : g_upper
                    assign stage_out[gs][gi] = u_q[gi] ^ u_q[gi + (1 << gs)];
                end else begin : g_lower
                    assign stage_out[gs][gi] = u_q[gi];
                end
            end
        end
    endgenerate

    assign xform_v = stage_out[stage_q];

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        crc_d       = crc_q;
        bit_idx_d   = bit_idx_q;
        stage_d     = stage_q;
        u_d         = u_q;
        cw_d        = cw_q;
        out_valid_d = out_valid_q;
        frame_cnt_d = frame_cnt_q;
`ifdef POLAR_ENC_ERRINJ_EN
        mask_d      = mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d    = bus.data_in;
                    crc_d     = CRC_INIT;
                    bit_idx_d = 5'd23;
`ifdef POLAR_ENC_ERRINJ_EN
                    mask_d    = bus.err_mask;
`endif
                    state_d   = CRC;
                end
            end
            CRC: begin
                crc_d     = crc_step;
                bit_idx_d = bit_idx_q - 5'd1;
                if (bit_idx_q == 5'd0) state_d = BUILD;
            end
            BUILD: begin
                u_d     = u_build;
                stage_d = 3'd0;
                state_d = XFORM;
            end
            XFORM: begin
                u_d     = xform_v;
                stage_d = stage_q + 3'd1;
                if (stage_q == 3'd5) begin
                    cw_d        = xform_v ^ inj_mask;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            crc_q       <= '0;
            bit_idx_q   <= '0;
            stage_q     <= '0;
            u_q         <= '0;
            cw_q        <= '0;
            out_valid_q <= 1'b0;
            frame_cnt_q <= '0;
`ifdef POLAR_ENC_ERRINJ_EN
            mask_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            crc_q       <= crc_d;
            bit_idx_q   <= bit_idx_d;
            stage_q     <= stage_d;
            u_q         <= u_d;
            cw_q        <= cw_d;
            out_valid_q <= out_valid_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef POLAR_ENC_ERRINJ_EN
            mask_q      <= mask_d;
`endif
        end
    end

    // in_ready is gated by rst_n so it reads 0 while reset is asserted.
    assign bus.in_ready  = rst_n && (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.cw_out    = cw_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_polar64_crc16_encoder.sv
// Bench for polar64_crc16_encoder: vector table plus random payloads against a
// long-division CRC and subset-sum polar transform model; mid-frame reset and counter wrap.
module tb_polar64_crc16_encoder;

    logic clk;
    logic rst_n;

    polar64_crc16_encoder_if bus ();

    polar64_crc16_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_fc;

    int info_pos [0:39] = '{13, 14, 15, 19, 21, 22, 23, 25, 26, 27, 28, 29, 30, 31,
                            35, 37, 38, 39, 41, 42, 43, 44, 45, 46, 47,
                            49, 50, 51, 52, 53, 54, 55, 56, 57, 58, 59, 60, 61, 62, 63};

    typedef struct {
        logic [23:0] data;
        logic [63:0] mask;
        int          hold;
        logic [63:0] exp_cw;
    } vec_t;

    vec_t tv [0:5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // CRC as remainder of (payload * x^16 + init * x^24) modulo 0x11021.
    function automatic logic [15:0] ref_crc(input logic [23:0] d);
        logic [39:0] r;
        r = {d, 16'h0000} ^ {16'hFFFF, 24'h000000};
        for (int i = 39; i >= 16; i--) begin
            if (r[i]) r = r ^ (40'h11021 << (i - 16));
        end
        return r[15:0];
    endfunction

    // x[a] = XOR of u[b] over every b whose bit set contains a's bit set (u times F^{(x)6}).
    function automatic logic [63:0] ref_encode(input logic [23:0] d);
        logic [63:0] u;
        logic [63:0] x;
        logic [15:0] c;
        c = ref_crc(d);
        u = '0;
        for (int k = 0; k < 24; k++) u[info_pos[k]] = d[23 - k];
        for (int k = 0; k < 16; k++) u[info_pos[24 + k]] = c[15 - k];
        for (int a = 0; a < 64; a++) begin
            x[a] = 1'b0;
            for (int b = 0; b < 64; b++) begin
                if ((b & a) == a) x[a] = x[a] ^ u[b];
            end
        end
        return x;
    endfunction

    function automatic logic [63:0] ref_cw(input logic [23:0] d, input logic [63:0] m);
`ifdef POLAR_ENC_ERRINJ_EN
        return ref_encode(d) ^ m;
`else
        return ref_encode(d) ^ (m & 64'h0);
`endif
    endfunction

    task automatic drive_mask(input logic [63:0] m);
`ifdef POLAR_ENC_ERRINJ_EN
        bus.err_mask = m;
`else
        if (m == 64'h0) begin end
`endif
    endtask

    // Waits for in_ready and asserts in_valid; returns after the accept edge (+1).
    task automatic accept_frame(input logic [23:0] d, input logic [63:0] m, output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("in_ready_timeout", 64'(bus.in_ready), 64'h1);
            ok = 1'b0;
            return;
        end
        bus.data_in   = d;
        drive_mask(m);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string tag, input logic [23:0] d, input logic [63:0] m,
                             input int hold, input logic [63:0] exp_cw);
        bit          ok;
        bit          rdy_low;
        bit          stable;
        int          lat;
        logic [63:0] got;
        accept_frame(d, m, ok);
        if (!ok) return;
        lat     = 0;
        rdy_low = 1'b1;
        while (lat < 40) begin
            @(negedge clk);
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.data_in   = 24'($urandom);
            drive_mask({$urandom, $urandom});
            bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            lat++;
            if (bus.in_ready) rdy_low = 1'b0;
            if (bus.out_valid) break;
        end
        check({tag, "_latency"}, 64'(lat), 64'd31);
        if (!bus.out_valid) return;
        check({tag, "_cw"}, bus.cw_out, exp_cw);
        got    = bus.cw_out;
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (bus.cw_out !== got || bus.out_valid !== 1'b1) stable = 1'b0;
            if (bus.in_ready) rdy_low = 1'b0;
        end
        if (hold > 0) check({tag, "_hold_stable"}, 64'(stable), 64'h1);
        check({tag, "_in_ready_low"}, 64'(rdy_low), 64'h1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(posedge clk);
        #1;
        exp_fc = exp_fc + 16'd1;
        check({tag, "_out_valid_drop"}, 64'(bus.out_valid), 64'h0);
        check({tag, "_in_ready_after"}, 64'(bus.in_ready), 64'h1);
        check({tag, "_frame_cnt"}, 64'(bus.frame_cnt), 64'(exp_fc));
        check({tag, "_cw_retained"}, bus.cw_out, got);
        $display("frame %s data=%h hold=%0d cw=%h frame_cnt=%h", tag, d, hold, got, bus.frame_cnt);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bit          ok;
        logic [23:0] rd;
        logic [63:0] rm;

        tv[0] = '{data: 24'h000000, mask: 64'h0,                    hold: 0,  exp_cw: 64'h0};
        tv[1] = '{data: 24'hA5C3F0, mask: 64'h0,                    hold: 10, exp_cw: 64'h0};
        tv[2] = '{data: 24'h123456, mask: 64'h8000_0000_0000_0001,  hold: 1,  exp_cw: 64'h0};
        tv[3] = '{data: 24'h123456, mask: 64'h8000_0000_0001_0001,  hold: 2,  exp_cw: 64'h0};
        tv[4] = '{data: 24'hFFFFFF, mask: 64'h8000_0400_0000_0001,  hold: 3,  exp_cw: 64'h0};
        tv[5] = '{data: 24'h800001, mask: 64'h0,                    hold: 0,  exp_cw: 64'h0};
        for (int i = 0; i < 6; i++) tv[i].exp_cw = ref_cw(tv[i].data, tv[i].mask);

        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.data_in   = 24'h000000;
        bus.out_ready = 1'b0;
        drive_mask(64'h0);
        exp_fc        = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'h0);
        check("rst_out_valid", 64'(bus.out_valid), 64'h0);
        check("rst_cw", bus.cw_out, 64'h0);
        check("rst_frame_cnt", 64'(bus.frame_cnt), 64'h0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        #1;
        check("rel_in_ready", 64'(bus.in_ready), 64'h1);

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("tv%0d", i), tv[i].data, tv[i].mask, tv[i].hold, tv[i].exp_cw);
        end

        // Reset pulse while the transform is at stage 3.
        accept_frame(24'h5A5A5A, 64'h0, ok);
        if (ok) begin
            bus.in_valid = 1'b0;
            repeat (28) @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            exp_fc = 16'h0000;
            check("midrst_out_valid", 64'(bus.out_valid), 64'h0);
            check("midrst_cw", bus.cw_out, 64'h0);
            check("midrst_frame_cnt", 64'(bus.frame_cnt), 64'h0);
            check("midrst_in_ready", 64'(bus.in_ready), 64'h0);
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            check("midrst_rel_in_ready", 64'(bus.in_ready), 64'h1);
            $display("mid-frame reset applied");
        end
        run_frame("post_rst", 24'hC0FFEE, 64'h0, 1, ref_cw(24'hC0FFEE, 64'h0));

        for (int i = 0; i < 40; i++) begin
            rd = 24'($urandom);
            rm = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            run_frame($sformatf("rnd%0d", i), rd, rm, int'($urandom_range(0, 3)), ref_cw(rd, rm));
        end

        // Counter wrap: preload the count register, then deliver one frame.
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.frame_cnt_q;
        #1;
        exp_fc = 16'hFFFF;
        check("preload_frame_cnt", 64'(bus.frame_cnt), 64'hFFFF);
        run_frame("wrap", 24'h0F0F0F, 64'h0, 0, ref_cw(24'h0F0F0F, 64'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "global timeout");
    end

endmodule
